// File: rtl/display_scan_controller.sv
// Time-multiplexed scan driver for an 8-digit 7-segment display.
// Steps the digit select per slot and blanks the anodes at the start of each slot.
module display_scan_controller #(
  parameter int unsigned SLOT_CYCLES  = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [7:0] digit_mask,
  input  logic [7:0] dp_in,
  output logic [3:0] select,
  output logic [7:0] anode,
  output logic       dp_out,
  output logic       slot_tick
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

  // cnt/pos_sel name the slot position that the next enabled edge presents on
  // the registered outputs, so the first enabled cycle after reset is cycle 0.
  logic [CW-1:0] cnt;
  logic [2:0]    pos_sel;
  logic [2:0]    sel_q;
  logic          lit;

  always_comb begin
    lit = (cnt >= BLANK) && digit_mask[pos_sel];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      pos_sel   <= '0;
      sel_q     <= '0;
      anode     <= '1;
      dp_out    <= 1'b1;
      slot_tick <= 1'b0;
    end else if (en) begin
      sel_q     <= pos_sel;
      slot_tick <= (cnt == '0);
      if (lit) begin
        anode  <= ~(8'b1 << pos_sel);
        dp_out <= ~dp_in[pos_sel];
      end else begin
        anode  <= '1;
        dp_out <= 1'b1;
      end
      if (cnt == LAST) begin
        cnt     <= '0;
        pos_sel <= pos_sel + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      anode     <= '1;
      dp_out    <= 1'b1;
      slot_tick <= 1'b0;
    end
  end

  assign select = {1'b0, sel_q};

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench for display_scan_controller with SLOT_CYCLES=10, BLANK_CYCLES=2.
module tb_display_scan_controller;

  localparam int unsigned SLOT  = 10;
  localparam int unsigned BLANK = 2;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] an;
    logic       dp;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] digit_mask = '0;
  logic [7:0] dp_in = '0;
  logic [3:0] select;
  logic [7:0] anode;
  logic       dp_out;
  logic       slot_tick;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];

  // Reference model: linear frame position (0..8*SLOT-1) of the next presented cycle.
  int         m_pos = 0;
  logic [3:0] m_sel = '0;

  display_scan_controller #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .digit_mask(digit_mask), .dp_in(dp_in),
    .select(select), .anode(anode), .dp_out(dp_out), .slot_tick(slot_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic e, input logic [7:0] m, input logic [7:0] d);
    exp_t x;
    int   k;
    int   c;
    bit   on;
    reset_n = rn; en = e; digit_mask = m; dp_in = d;
    if (!rn) begin
      m_pos = 0; m_sel = 4'd0;
      x = '{sel: 4'd0, an: 8'hFF, dp: 1'b1, tick: 1'b0};
    end else if (!e) begin
      x = '{sel: m_sel, an: 8'hFF, dp: 1'b1, tick: 1'b0};
    end else begin
      k = m_pos / SLOT;
      c = m_pos % SLOT;
      m_sel = 4'(k);
      on = (c >= BLANK) && m[k];
      x.sel  = m_sel;
      x.tick = (c == 0);
      x.an   = on ? ~(8'h01 << k) : 8'hFF;
      x.dp   = on ? ~d[k] : 1'b1;
      m_pos = (m_pos + 1) % (8 * SLOT);
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 8'd0, 8'd1);
    end else begin
      x = sb.pop_front();
      check_eq("select", {4'd0, select}, {4'd0, x.sel});
      check_eq("anode", anode, x.an);
      check_eq("dp_out", {7'd0, dp_out}, {7'd0, x.dp});
      check_eq("slot_tick", {7'd0, slot_tick}, {7'd0, x.tick});
    end
  endtask

  initial begin
    // T1: reset held three cycles with en high
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'hFF, 8'h00);
    // T2: full scan, one frame plus wrap
    for (int i = 0; i < 81; i++) step(1'b1, 1'b1, 8'hFF, 8'h00);
    // T3: masking
    step(1'b0, 1'b1, 8'h05, 8'h00);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 8'h05, 8'h00);
    // T4: freeze at slot 3 cycle 5 for four cycles
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 35; i++) step(1'b1, 1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 8'hFF, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 8'hFF, 8'h00);
    // T5: reset at slot 5 cycle 7, then a full slot 0 and into slot 1
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 57; i++) step(1'b1, 1'b1, 8'hFF, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 8'h00);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'hFF, 8'h00);
    // T6: decimal point on digit 7 only
    step(1'b0, 1'b1, 8'hFF, 8'h80);
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 8'hFF, 8'h80);
    // Random mid-slot mask/dp changes, en toggling and occasional reset
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 5) != 0),
           8'($urandom), 8'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
